// File: rtl/cc_pkg.sv
// Shared encodings, geometry and FSM state type for the read-only
// direct-mapped cache controller.
package cc_pkg;

  localparam int unsigned CC_IDX_W = 9;
  localparam int unsigned CC_TAG_W = 17;
  localparam int unsigned ID_W     = 4;
  localparam int unsigned WORDS    = 8;
  localparam int unsigned WORD_W   = 64;
  localparam int unsigned LINE_W   = WORDS * WORD_W;
  localparam int unsigned BEAT_W   = 3;

  localparam logic [BEAT_W-1:0] LAST_BEAT      = 3'd7;
  localparam logic [1:0]        AXI_BURST_WRAP = 2'b10;
  localparam logic [1:0]        AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0]        AXI_LEN_LINE   = 4'd7;
  localparam logic [2:0]        AXI_SIZE_8B    = 3'd3;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StHit,
    StMreq,
    StMdata,
    StFill
  } cc_state_e;

  typedef logic [WORDS-1:0][WORD_W-1:0] line_t;

endpackage

// File: rtl/cc_apb_regs.sv
// APB slave exposing a read-only IP version register at offset 0x000.
module cc_apb_regs #(
  parameter logic [31:0] IP_VER = 32'h0000_0000
) (
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [11:0] paddr_i,
  input  logic [31:0] pwdata_i,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic [31:0] prdata_o
);

  // Writes have no effect and the read mux is address-only, so control is unused.
  logic unused_apb;
  assign unused_apb = ^{psel_i, penable_i, pwrite_i, pwdata_i};

  assign pready_o  = 1'b1;
  assign pslverr_o = 1'b0;
  assign prdata_o  = (paddr_i == 12'h000) ? IP_VER : 32'h0000_0000;

endmodule

// File: rtl/cc_top.sv
// Blocking read-only direct-mapped cache: 512 x 64 B lines, tag/data in external SRAM,
// critical-word-first 8 x 64b wrapping bursts on both AXI read ports.
module cc_top
  import cc_pkg::*;
#(
  parameter logic [31:0] IP_VER = 32'h0000_0000,
  parameter int unsigned IDX_W  = CC_IDX_W,
  parameter int unsigned TAG_W  = CC_TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  // APB
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [11:0]       paddr_i,
  input  logic [31:0]       pwdata_i,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic [31:0]       prdata_o,
  // Interconnect AXI read slave
  input  logic [ID_W-1:0]   inct_arid_i,
  input  logic [31:0]       inct_araddr_i,
  input  logic [3:0]        inct_arlen_i,
  input  logic [2:0]        inct_arsize_i,
  input  logic [1:0]        inct_arburst_i,
  input  logic              inct_arvalid_i,
  output logic              inct_arready_o,
  output logic [ID_W-1:0]   inct_rid_o,
  output logic [63:0]       inct_rdata_o,
  output logic [1:0]        inct_rresp_o,
  output logic              inct_rlast_o,
  output logic              inct_rvalid_o,
  input  logic              inct_rready_i,
  // Memory AXI read master
  output logic [ID_W-1:0]   mem_arid_o,
  output logic [31:0]       mem_araddr_o,
  output logic [3:0]        mem_arlen_o,
  output logic [2:0]        mem_arsize_o,
  output logic [1:0]        mem_arburst_o,
  output logic              mem_arvalid_o,
  input  logic              mem_arready_i,
  input  logic [ID_W-1:0]   mem_rid_i,
  input  logic [63:0]       mem_rdata_i,
  input  logic [1:0]        mem_rresp_i,
  input  logic              mem_rlast_i,
  input  logic              mem_rvalid_i,
  output logic              mem_rready_o,
  // Tag/data SRAM
  output logic              rden_o,
  output logic [IDX_W-1:0]  raddr_o,
  input  logic [TAG_W:0]    rdata_tag_i,
  input  logic [LINE_W-1:0] rdata_data_i,
  output logic              wren_o,
  output logic [IDX_W-1:0]  waddr_o,
  output logic [TAG_W:0]    wdata_tag_o,
  output logic [LINE_W-1:0] wdata_data_o
);

  cc_apb_regs #(
    .IP_VER (IP_VER)
  ) u_apb_regs (
    .psel_i    (psel_i),
    .penable_i (penable_i),
    .pwrite_i  (pwrite_i),
    .paddr_i   (paddr_i),
    .pwdata_i  (pwdata_i),
    .pready_o  (pready_o),
    .pslverr_o (pslverr_o),
    .prdata_o  (prdata_o)
  );

  // Burst shape is fixed by the interconnect, and the memory R id is implied by the
  // single outstanding request.
  logic unused_in;
  assign unused_in = ^{inct_arlen_i, inct_arsize_i, inct_arburst_i, inct_araddr_i[2:0], mem_rid_i};

  cc_state_e         state_q;
  logic [ID_W-1:0]   id_q;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [BEAT_W-1:0] word_q;
  logic [BEAT_W-1:0] beat_q;
  line_t             line_q;

  logic [BEAT_W-1:0] cur_word;
  logic              hit;

  // Wrap within the line by relying on 3-bit overflow.
  assign cur_word = word_q + beat_q;
  assign hit      = rdata_tag_i[TAG_W] & (rdata_tag_i[TAG_W-1:0] == tag_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      id_q    <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      beat_q  <= '0;
      line_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (inct_arvalid_i) begin
            id_q    <= inct_arid_i;
            tag_q   <= inct_araddr_i[6+IDX_W +: TAG_W];
            idx_q   <= inct_araddr_i[6 +: IDX_W];
            word_q  <= inct_araddr_i[5:3];
            beat_q  <= '0;
            state_q <= StLookup;
          end
        end
        StLookup: begin
          if (hit) begin
            line_q  <= rdata_data_i;
            state_q <= StHit;
          end else begin
            state_q <= StMreq;
          end
        end
        StHit: begin
          if (inct_rready_i) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) state_q <= StIdle;
          end
        end
        StMreq: begin
          if (mem_arready_i) state_q <= StMdata;
        end
        StMdata: begin
          if (mem_rvalid_i && inct_rready_i) begin
            line_q[cur_word] <= mem_rdata_i;
            beat_q           <= beat_q + 1'b1;
            if (mem_rlast_i) state_q <= StFill;
          end
        end
        StFill: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    inct_arready_o = 1'b0;
    inct_rid_o     = '0;
    inct_rdata_o   = '0;
    inct_rresp_o   = '0;
    inct_rlast_o   = 1'b0;
    inct_rvalid_o  = 1'b0;
    mem_arid_o     = '0;
    mem_araddr_o   = '0;
    mem_arlen_o    = '0;
    mem_arsize_o   = '0;
    mem_arburst_o  = '0;
    mem_arvalid_o  = 1'b0;
    mem_rready_o   = 1'b0;
    rden_o         = 1'b0;
    raddr_o        = '0;
    wren_o         = 1'b0;
    waddr_o        = '0;
    wdata_tag_o    = '0;
    wdata_data_o   = '0;
    unique case (state_q)
      StIdle: begin
        inct_arready_o = 1'b1;
        // Launch the SRAM read in the accept cycle so LOOKUP sees the tag next cycle.
        if (inct_arvalid_i) begin
          rden_o  = 1'b1;
          raddr_o = inct_araddr_i[6 +: IDX_W];
        end
      end
      StHit: begin
        inct_rvalid_o = 1'b1;
        inct_rid_o    = id_q;
        inct_rdata_o  = line_q[cur_word];
        inct_rresp_o  = AXI_RESP_OKAY;
        inct_rlast_o  = (beat_q == LAST_BEAT);
      end
      StMreq: begin
        mem_arvalid_o = 1'b1;
        mem_arid_o    = id_q;
        mem_araddr_o  = {tag_q, idx_q, word_q, 3'b000};
        mem_arlen_o   = AXI_LEN_LINE;
        mem_arsize_o  = AXI_SIZE_8B;
        mem_arburst_o = AXI_BURST_WRAP;
      end
      StMdata: begin
        inct_rvalid_o = mem_rvalid_i;
        mem_rready_o  = inct_rready_i;
        inct_rid_o    = id_q;
        inct_rdata_o  = mem_rdata_i;
        inct_rresp_o  = mem_rresp_i;
        inct_rlast_o  = mem_rlast_i;
      end
      StFill: begin
        wren_o       = 1'b1;
        waddr_o      = idx_q;
        wdata_tag_o  = {1'b1, tag_q};
        wdata_data_o = line_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cc_top.sv
// Bench for cc_top: SRAM and memory-slave models, table vectors, reset abort and random soak
// checked against an address-level cache/memory reference model.
module tb_cc_top;
  import cc_pkg::*;

  localparam logic [31:0] IP_VER = 32'h1234_5678;

  logic         clk, rst_n;
  logic         psel_i, penable_i, pwrite_i, pready_o, pslverr_o;
  logic [11:0]  paddr_i;
  logic [31:0]  pwdata_i, prdata_o;
  logic [3:0]   inct_arid_i, inct_arlen_i, inct_rid_o;
  logic [31:0]  inct_araddr_i;
  logic [2:0]   inct_arsize_i;
  logic [1:0]   inct_arburst_i, inct_rresp_o;
  logic         inct_arvalid_i, inct_arready_o, inct_rlast_o, inct_rvalid_o, inct_rready_i;
  logic [63:0]  inct_rdata_o;
  logic [3:0]   mem_arid_o, mem_arlen_o, mem_rid_i;
  logic [31:0]  mem_araddr_o;
  logic [2:0]   mem_arsize_o;
  logic [1:0]   mem_arburst_o, mem_rresp_i;
  logic         mem_arvalid_o, mem_arready_i, mem_rlast_i, mem_rvalid_i, mem_rready_o;
  logic [63:0]  mem_rdata_i;
  logic         rden_o, wren_o;
  logic [8:0]   raddr_o, waddr_o;
  logic [17:0]  rdata_tag_i, wdata_tag_o;
  logic [511:0] rdata_data_i, wdata_data_o;

  cc_top #(
    .IP_VER (IP_VER)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .psel_i         (psel_i),
    .penable_i      (penable_i),
    .pwrite_i       (pwrite_i),
    .paddr_i        (paddr_i),
    .pwdata_i       (pwdata_i),
    .pready_o       (pready_o),
    .pslverr_o      (pslverr_o),
    .prdata_o       (prdata_o),
    .inct_arid_i    (inct_arid_i),
    .inct_araddr_i  (inct_araddr_i),
    .inct_arlen_i   (inct_arlen_i),
    .inct_arsize_i  (inct_arsize_i),
    .inct_arburst_i (inct_arburst_i),
    .inct_arvalid_i (inct_arvalid_i),
    .inct_arready_o (inct_arready_o),
    .inct_rid_o     (inct_rid_o),
    .inct_rdata_o   (inct_rdata_o),
    .inct_rresp_o   (inct_rresp_o),
    .inct_rlast_o   (inct_rlast_o),
    .inct_rvalid_o  (inct_rvalid_o),
    .inct_rready_i  (inct_rready_i),
    .mem_arid_o     (mem_arid_o),
    .mem_araddr_o   (mem_araddr_o),
    .mem_arlen_o    (mem_arlen_o),
    .mem_arsize_o   (mem_arsize_o),
    .mem_arburst_o  (mem_arburst_o),
    .mem_arvalid_o  (mem_arvalid_o),
    .mem_arready_i  (mem_arready_i),
    .mem_rid_i      (mem_rid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_rresp_i    (mem_rresp_i),
    .mem_rlast_i    (mem_rlast_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rready_o   (mem_rready_o),
    .rden_o         (rden_o),
    .raddr_o        (raddr_o),
    .rdata_tag_i    (rdata_tag_i),
    .rdata_data_i   (rdata_data_i),
    .wren_o         (wren_o),
    .waddr_o        (waddr_o),
    .wdata_tag_o    (wdata_tag_o),
    .wdata_data_o   (wdata_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Backing memory, filled with random words on first touch.
  logic [63:0] mem_img [logic [31:0]];
  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    if (!mem_img.exists(a)) mem_img[a] = {$urandom, $urandom};
    return mem_img[a];
  endfunction

  // Reference cache state: which tag each set should hold.
  bit          ref_valid [512];
  logic [16:0] ref_tag   [512];
  task automatic ref_clear();
    for (int i = 0; i < 512; i++) ref_valid[i] = 1'b0;
  endtask

  // SRAM model: 1-cycle read latency, tag array cleared by reset.
  logic [17:0]  sram_tag  [512];
  logic [511:0] sram_data [512];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) sram_tag[i] <= '0;
    end else begin
      if (rden_o) begin
        rdata_tag_i  <= sram_tag[raddr_o];
        rdata_data_i <= sram_data[raddr_o];
      end
      if (wren_o) begin
        sram_tag[waddr_o]  <= wdata_tag_o;
        sram_data[waddr_o] <= wdata_data_o;
      end
    end
  end

  int          wr_count = 0;
  logic [8:0]  last_waddr;
  logic [17:0] last_wtag;
  always @(negedge clk) begin
    if (rst_n && wren_o) begin
      wr_count++;
      last_waddr = waddr_o;
      last_wtag  = wdata_tag_o;
    end
  end

  // Memory AXI slave: random AR accept delay and random R gaps, drives at posedge+1.
  int          ar_count = 0;
  logic [31:0] last_ar_addr;
  logic [3:0]  last_ar_len, last_ar_id;
  logic [2:0]  last_ar_size;
  logic [1:0]  last_ar_burst;
  initial begin : mem_slave
    bit          busy, ar_hs, r_hs;
    int          beat;
    logic [31:0] base;
    logic [2:0]  w0, wk;
    busy = 0; beat = 0; base = '0; w0 = '0;
    mem_arready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    mem_rresp_i = '0; mem_rlast_i = 0; mem_rid_i = '0;
    forever begin
      @(negedge clk);
      ar_hs = mem_arvalid_o && mem_arready_i;
      r_hs  = mem_rvalid_i && mem_rready_o;
      if (ar_hs) begin
        ar_count++;
        last_ar_addr  = mem_araddr_o;
        last_ar_len   = mem_arlen_o;
        last_ar_size  = mem_arsize_o;
        last_ar_burst = mem_arburst_o;
        last_ar_id    = mem_arid_o;
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        busy = 0; mem_arready_i = 0; mem_rvalid_i = 0; mem_rlast_i = 0;
        continue;
      end
      if (!busy) begin
        if (ar_hs) begin
          busy = 1; beat = 0; mem_arready_i = 0;
          base = {last_ar_addr[31:6], 6'b0};
          w0 = last_ar_addr[5:3];
          mem_rid_i = last_ar_id;
        end else begin
          mem_arready_i = ($urandom_range(0, 2) != 0);
        end
      end else begin
        if (r_hs) begin
          beat++;
          mem_rvalid_i = 0;
          mem_rlast_i  = 0;
        end
        if (beat == 8) begin
          busy = 0;
        end else if (!mem_rvalid_i && $urandom_range(0, 3) != 0) begin
          wk = w0 + 3'(beat);
          mem_rvalid_i = 1;
          mem_rdata_i  = mem_rd({base[31:6], wk, 3'b000});
          mem_rlast_i  = (beat == 7);
        end
      end
    end
  end

  // One interconnect read; checks every beat against the memory image. abort_at < 8 stops early.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input bit bp,
                         input int abort_at, output bit was_miss);
    int          ar0, t, nbeat;
    bit          stalled, model_hit;
    logic [63:0] held;
    logic [2:0]  w;
    logic [8:0]  idx;
    logic [16:0] tag;
    idx = addr[14:6];
    tag = addr[31:15];
    ar0 = ar_count;
    model_hit = ref_valid[idx] && (ref_tag[idx] == tag);
    was_miss = 0;
    held = '0;
    @(posedge clk);
    #1;
    inct_arvalid_i = 1; inct_araddr_i = addr; inct_arid_i = id; inct_rready_i = 0;
    t = 0;
    forever begin
      @(negedge clk);
      if (inct_arready_o) break;
      t++;
      if (t > 100) begin
        fail_now("ar_accept_timeout");
        inct_arvalid_i = 0;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("sram_rden", rden_o, 1'b1);
    check("sram_raddr", raddr_o, idx);
    @(posedge clk);
    #1;
    inct_arvalid_i = 0;
    inct_rready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    nbeat = 0; stalled = 0; t = 0;
    while (nbeat < abort_at) begin
      @(negedge clk);
      if (stalled) begin
        check("stall_rvalid", inct_rvalid_o, 1'b1);
        check("stall_rdata", inct_rdata_o, held);
      end
      stalled = 0;
      if (inct_rvalid_o) begin
        if (inct_rready_i) begin
          w = addr[5:3] + nbeat[2:0];
          check("beat_data", inct_rdata_o, mem_rd({addr[31:6], w, 3'b000}));
          check("beat_rid", inct_rid_o, id);
          check("beat_rresp", inct_rresp_o, 2'b00);
          check("beat_rlast", inct_rlast_o, nbeat == 7);
          nbeat++;
        end else begin
          stalled = 1;
          held = inct_rdata_o;
        end
      end
      if (nbeat >= abort_at) break;
      t++;
      if (t > 500) begin
        fail_now("r_beat_timeout");
        return;
      end
      @(posedge clk);
      #1;
      inct_rready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    was_miss = (ar_count != ar0);
    if (abort_at == 8) begin
      check("miss_vs_model", was_miss, !model_hit);
      if (was_miss) begin
        check("mem_araddr", last_ar_addr, {addr[31:3], 3'b000});
        check("mem_arlen", last_ar_len, 4'd7);
        check("mem_arsize", last_ar_size, 3'd3);
        check("mem_arburst", last_ar_burst, 2'b10);
        check("mem_arid", last_ar_id, id);
      end
      ref_valid[idx] = 1;
      ref_tag[idx]   = tag;
    end
  endtask

  task automatic apb_read(input logic [11:0] addr, input logic [31:0] exp);
    @(posedge clk);
    #1;
    psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = addr;
    @(posedge clk);
    #1;
    penable_i = 1;
    @(negedge clk);
    check("apb_pready", pready_o, 1'b1);
    check("apb_pslverr", pslverr_o, 1'b0);
    check("apb_prdata", prdata_o, exp);
    @(posedge clk);
    #1;
    psel_i = 0; penable_i = 0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    bit          bp;
    bit          exp_miss;
    bit          chk_wr;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] soak_line [80];

  initial begin : main
    bit miss;
    int wr0;
    vecs[0]  = '{32'h0000_1240, 4'd3,  1'b0, 1'b1, 1'b1};
    vecs[1]  = '{32'h0000_1258, 4'd5,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h0000_1258, 4'd6,  1'b1, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_9240, 4'd1,  1'b0, 1'b1, 1'b1};
    vecs[4]  = '{32'h0000_1240, 4'd2,  1'b1, 1'b1, 1'b1};
    vecs[5]  = '{32'h0000_1278, 4'd7,  1'b1, 1'b0, 1'b0};
    vecs[6]  = '{32'h0000_0000, 4'd0,  1'b0, 1'b1, 1'b1};
    vecs[7]  = '{32'hFFFF_FFC8, 4'd15, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{32'hFFFF_FFF0, 4'd9,  1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h0000_5000, 4'd4,  1'b0, 1'b1, 1'b0};
    vecs[10] = '{32'h0000_5008, 4'd8,  1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h0000_9258, 4'd10, 1'b1, 1'b1, 1'b1};

    rst_n = 0;
    psel_i = 0; penable_i = 0; pwrite_i = 0; paddr_i = '0; pwdata_i = '0;
    inct_arid_i = '0; inct_araddr_i = '0; inct_arlen_i = 4'd7; inct_arsize_i = 3'd3;
    inct_arburst_i = 2'b10; inct_arvalid_i = 0; inct_rready_i = 0;
    ref_clear();
    repeat (3) @(negedge clk);
    check("rst_arready", inct_arready_o, 1'b1);
    check("rst_rvalid", inct_rvalid_o, 1'b0);
    check("rst_mem_arvalid", mem_arvalid_o, 1'b0);
    check("rst_mem_araddr", mem_araddr_o, 32'h0);
    check("rst_wren", wren_o, 1'b0);
    check("rst_rden", rden_o, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1;

    apb_read(12'h000, IP_VER);
    apb_read(12'h004, 32'h0);
    @(posedge clk);
    #1;
    psel_i = 1; pwrite_i = 1; paddr_i = 12'h000; pwdata_i = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    penable_i = 1;
    @(posedge clk);
    #1;
    psel_i = 0; penable_i = 0; pwrite_i = 0;
    apb_read(12'h000, IP_VER);
    apb_read(12'hFFC, 32'h0);

    for (int i = 0; i < 12; i++) begin
      wr0 = wr_count;
      do_read(vecs[i].addr, vecs[i].id, vecs[i].bp, 8, miss);
      check($sformatf("vec%0d_miss", i), miss, vecs[i].exp_miss);
      if (vecs[i].chk_wr) begin
        repeat (2) @(negedge clk);
        check($sformatf("vec%0d_wr_count", i), wr_count - wr0, 1);
        check($sformatf("vec%0d_waddr", i), last_waddr, vecs[i].addr[14:6]);
        check($sformatf("vec%0d_wtag", i), last_wtag, {1'b1, vecs[i].addr[31:15]});
      end
    end

    // Reset in the middle of a miss burst: no fill, and the cache comes back empty.
    wr0 = wr_count;
    do_read(32'h0000_2A80, 4'd6, 1'b0, 3, miss);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    check("abort_arready", inct_arready_o, 1'b1);
    check("abort_rvalid", inct_rvalid_o, 1'b0);
    check("abort_mem_arvalid", mem_arvalid_o, 1'b0);
    check("abort_wren", wren_o, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    inct_rready_i = 0;
    ref_clear();
    repeat (3) @(negedge clk);
    check("abort_no_write", wr_count, wr0);
    do_read(32'h0000_2A80, 4'd6, 1'b0, 8, miss);
    check("abort_refetch_miss", miss, 1'b1);
    do_read(32'h0000_1258, 4'd2, 1'b1, 8, miss);
    check("abort_cleared_miss", miss, 1'b1);

    // Soak: 80 misses on distinct sets, then random-word reads that must all hit.
    for (int i = 0; i < 80; i++) begin
      soak_line[i] = {17'($urandom), 9'((i * 37 + 5) % 512), 6'b0};
      do_read(soak_line[i], 4'($urandom), 1'($urandom_range(0, 1)), 8, miss);
    end
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a;
      a = soak_line[$urandom_range(0, 79)] | {26'b0, 3'($urandom), 3'b000};
      do_read(a, 4'($urandom), 1'($urandom_range(0, 1)), 8, miss);
      check("soak_hit", miss, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
